mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one physical Wishbone-style line memory port (128-bit lines, 16-bit byte addresses) between the instruction-fetch requester and the data-memory requester of the LC-3b pipeline.
- Sits between the fetch/mem stages and the cache/memory.
- Provides round-robin arbitration when both requesters are pending, abort on requester withdrawal, and a per-transaction ack watchdog.

Parameters:
- TIMEOUT, 64: cycles a granted transaction may wait for mem_ack before it is error-terminated; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; TIMEOUT must be < 2**CNT_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_cyc  in  1  fetch bus cycle active
- imem_stb  in  1  fetch strobe
- imem_addr  in  16  fetch byte address (lc3b_word)
- imem_rdata  out  128  fetch read line (lc3b_data)
- imem_ack  out  1  fetch transfer complete
- imem_err  out  1  fetch transfer timed out
- dmem_cyc  in  1  data bus cycle active
- dmem_stb  in  1  data strobe
- dmem_we  in  1  1 = write
- dmem_sel  in  16  byte enables for the line
- dmem_addr  in  16  data byte address
- dmem_wdata  in  128  write line
- dmem_rdata  out  128  data read line
- dmem_ack  out  1  data transfer complete
- dmem_err  out  1  data transfer timed out
- mem_cyc, mem_stb, mem_we  out  1 each  to memory
- mem_sel  out  16  to memory
- mem_addr  out  16  to memory
- mem_wdata  out  128  to memory
- mem_rdata  in  128  from memory
- mem_ack  in  1  from memory

Behaviour:
- Request definition: req_x = x_cyc & x_stb.
- State machine arb_state_t {IDLE, SERVE_I, SERVE_D}. Reset (async, rst_n=0):
  - state=IDLE, last_grant=I (so dmem wins the first tie), watchdog=0.
  - Every output is 0 while rst_n=0, and outputs return to IDLE values on rst_n deassertion.
- IDLE:
  - mem_* outputs are all 0.
  - Only req_i: go to SERVE_I. Only req_d: go to SERVE_D.
  - Both pending: grant the requester not equal to last_grant.
  - Neither pending: stay in IDLE.
  - Arbitration latency is exactly 1 cycle: a request sampled at edge k is driven on mem_* during cycle k..k+1.
- SERVE_I (mem outputs are combinational from the granted requester):
  - mem_cyc=imem_cyc, mem_stb=imem_stb, mem_we=0, mem_sel=16'hFFFF, mem_addr=imem_addr, mem_wdata=0.
- SERVE_D:
  - mem_cyc=dmem_cyc, mem_stb=dmem_stb, mem_we=dmem_we, mem_sel=dmem_sel, mem_addr=dmem_addr, mem_wdata=dmem_wdata.
- Completion:
  - In SERVE_x with mem_ack=1: x_ack=1 in the same cycle (combinational pass-through).
  - Next state IDLE; last_grant<=x; watchdog<=0.
  - mem_ack while in IDLE, or routed to the non-granted side, is ignored (never forwarded).
- rdata: imem_rdata and dmem_rdata both carry mem_rdata unconditionally. Data is valid only with the corresponding ack.
- Abort:
  - In SERVE_x with x_cyc=0 and no mem_ack: mem_cyc falls the same cycle; next state IDLE.
  - last_grant is unchanged; no ack or err is issued.
- Watchdog:
  - Counts each cycle spent in SERVE_x without mem_ack.
  - When count==TIMEOUT-1 and mem_ack=0: x_err=1 for one cycle, next state IDLE, last_grant<=x, counter cleared.
  - mem_ack in the same cycle wins: ack is issued, no err.
  - Abort in the same cycle wins over timeout.
- Address: passed through unmodified; memory ignores addr[3:0]. The fetch stage selects its word locally.
- No back-to-back grants: there is always ≥1 IDLE cycle between transactions, and mem_cyc drops for that cycle.
- x_ack and x_err are never both 1. At most one of imem_ack/dmem_ack is 1 in any cycle.

Decomposition:
- lc3b_types gains:
  - arb_state_t enum
  - lc3b_mem_sel (logic [15:0])
  - lc3b_requester enum {REQ_I, REQ_D} for last_grant
- lc3b_word and lc3b_data are reused from the package.
- One sub-module, bus_watchdog:
  - Inputs: clk, rst_n, clear, count_en.
  - Output: expired. Parameters: TIMEOUT, CNT_W.
- All muxing and the FSM stay in mem_port_arbiter.

Test Plan:
- Reset mid-transaction:
  - Stimulus: assert rst_n=0 while in SERVE_D with mem_stb=1.
  - Response: all outputs 0 immediately; after release, state IDLE; first tie goes to dmem.
- Single fetch:
  - Stimulus: imem_cyc=stb=1, imem_addr=16'h3006; mem_ack=1 with mem_rdata=128'h…BEEF on cycle 3.
  - Response: mem_addr=16'h3006, mem_sel=16'hFFFF, mem_we=0; imem_ack=1 same cycle with imem_rdata=mem_rdata; dmem_ack=0.
- Tie and round-robin:
  - Stimulus: both requesters held continuously; memory acks 2 cycles after each strobe.
  - Response: grant order D, I, D, I, with one IDLE cycle between grants.
- Data write:
  - Stimulus: dmem_we=1, dmem_sel=16'h0003, dmem_addr=16'h4010, dmem_wdata=128'h1234.
  - Response: those values appear on mem_* exactly; dmem_ack follows mem_ack.
- Abort:
  - Stimulus: grant I, then drop imem_cyc before mem_ack.
  - Response: mem_cyc=0 that cycle, IDLE next cycle, no imem_ack or imem_err. A later mem_ack is ignored.
- Timeout with TIMEOUT=4:
  - Stimulus: grant D with no mem_ack.
  - Response: dmem_err=1 for exactly one cycle on the 4th SERVE_D cycle, then IDLE; next tie goes to I.
  - Repeat with mem_ack on that 4th cycle: dmem_ack=1, dmem_err=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared LC-3b memory-port types: line/word widths, byte-select vector,
// arbiter state encoding and requester identity.
package mem_port_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [15:0]  lc3b_mem_sel;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } lc3b_requester;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side Wishbone-style line buses that
// meet at the arbiter; the slave modport is the arbiter's view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic        imem_cyc;
  logic        imem_stb;
  lc3b_word    imem_addr;
  lc3b_data    imem_rdata;
  logic        imem_ack;
  logic        imem_err;

  logic        dmem_cyc;
  logic        dmem_stb;
  logic        dmem_we;
  lc3b_mem_sel dmem_sel;
  lc3b_word    dmem_addr;
  lc3b_data    dmem_wdata;
  lc3b_data    dmem_rdata;
  logic        dmem_ack;
  logic        dmem_err;

  logic        mem_cyc;
  logic        mem_stb;
  logic        mem_we;
  lc3b_mem_sel mem_sel;
  lc3b_word    mem_addr;
  lc3b_data    mem_wdata;
  lc3b_data    mem_rdata;
  logic        mem_ack;

  modport slave (
    input  imem_cyc, imem_stb, imem_addr,
    output imem_rdata, imem_ack, imem_err,
    input  dmem_cyc, dmem_stb, dmem_we, dmem_sel, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack, dmem_err,
    output mem_cyc, mem_stb, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output imem_cyc, imem_stb, imem_addr,
    input  imem_rdata, imem_ack, imem_err,
    output dmem_cyc, dmem_stb, dmem_we, dmem_sel, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack, dmem_err,
    input  mem_cyc, mem_stb, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Per-transaction ack watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT-th one. TIMEOUT of 0 disables it.
module bus_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expiry is judged on the cycle that would be the TIMEOUT-th counted one.
  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = count_en && (count == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-memory port between LC-3b fetch and
// data requesters, with abort on withdrawal and an ack watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_t    state;
  arb_state_t    next_state;
  lc3b_requester last_grant;
  lc3b_requester next_last_grant;

  logic req_i;
  logic req_d;
  logic granted_cyc;
  logic count_en;
  logic clear;
  logic expired;

  assign req_i = bus.imem_cyc & bus.imem_stb;
  assign req_d = bus.dmem_cyc & bus.dmem_stb;

  assign granted_cyc = (state == SERVE_I) ? bus.imem_cyc :
                       (state == SERVE_D) ? bus.dmem_cyc : 1'b0;

  // Counting stops on the cycle an ack or abort ends the transaction.
  assign count_en = (state != IDLE) && !bus.mem_ack && granted_cyc;
  assign clear    = (state == IDLE) || (next_state == IDLE);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .count_en (count_en),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ_I;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  assign bus.imem_rdata = rst_n ? bus.mem_rdata : '0;
  assign bus.dmem_rdata = rst_n ? bus.mem_rdata : '0;

  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    bus.mem_cyc     = 1'b0;
    bus.mem_stb     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_sel     = '0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.imem_ack    = 1'b0;
    bus.imem_err    = 1'b0;
    bus.dmem_ack    = 1'b0;
    bus.dmem_err    = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_i && req_d) begin
          next_state = (last_grant == REQ_I) ? SERVE_D : SERVE_I;
        end else if (req_i) begin
          next_state = SERVE_I;
        end else if (req_d) begin
          next_state = SERVE_D;
        end
      end

      SERVE_I: begin
        bus.mem_cyc  = bus.imem_cyc;
        bus.mem_stb  = bus.imem_stb;
        bus.mem_sel  = '1;
        bus.mem_addr = bus.imem_addr;
        // Priority: ack beats abort, abort beats timeout.
        if (bus.mem_ack) begin
          bus.imem_ack    = 1'b1;
          next_state      = IDLE;
          next_last_grant = REQ_I;
        end else if (!bus.imem_cyc) begin
          next_state = IDLE;
        end else if (expired) begin
          bus.imem_err    = 1'b1;
          next_state      = IDLE;
          next_last_grant = REQ_I;
        end
      end

      SERVE_D: begin
        bus.mem_cyc   = bus.dmem_cyc;
        bus.mem_stb   = bus.dmem_stb;
        bus.mem_we    = bus.dmem_we;
        bus.mem_sel   = bus.dmem_sel;
        bus.mem_addr  = bus.dmem_addr;
        bus.mem_wdata = bus.dmem_wdata;
        if (bus.mem_ack) begin
          bus.dmem_ack    = 1'b1;
          next_state      = IDLE;
          next_last_grant = REQ_D;
        end else if (!bus.dmem_cyc) begin
          next_state = IDLE;
        end else if (expired) begin
          bus.dmem_err    = 1'b1;
          next_state      = IDLE;
          next_last_grant = REQ_D;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 4-cycle watchdog;
// inputs change 2 time units after each rising edge, outputs are checked 1 later.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam lc3b_word I_ADDR = 16'h3006;
  localparam lc3b_word D_ADDR = 16'h4010;
  localparam lc3b_data RDATA  = 128'h0123_4567_89AB_CDEF_0000_1111_CAFE_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic ic, input logic istb, input logic dc, input logic dstb);
    bus.imem_cyc = ic;
    bus.imem_stb = istb;
    bus.dmem_cyc = dc;
    bus.dmem_stb = dstb;
  endtask

  initial begin
    rst_n          = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    bus.imem_addr  = I_ADDR;
    bus.dmem_we    = 1'b1;
    bus.dmem_sel   = 16'h0003;
    bus.dmem_addr  = D_ADDR;
    bus.dmem_wdata = 128'h1234;
    bus.mem_rdata  = RDATA;
    bus.mem_ack    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    checkOutput("por_mem_cyc", bus.mem_cyc, 1'b0);

    // Reset asserted in the middle of a data transaction.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    settle();
    checkOutput("rst_pre_stb", bus.mem_stb, 1'b1);
    rst_n       = 1'b0;
    bus.mem_ack = 1'b1;
    settle();
    checkOutput("rst_mem_cyc", bus.mem_cyc, 1'b0);
    checkOutput("rst_mem_stb", bus.mem_stb, 1'b0);
    checkOutput("rst_mem_we", bus.mem_we, 1'b0);
    checkOutput("rst_mem_sel", bus.mem_sel, 16'h0);
    checkOutput("rst_mem_addr", bus.mem_addr, 16'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 128'h0);
    checkOutput("rst_imem_rdata", bus.imem_rdata, 128'h0);
    checkOutput("rst_dmem_rdata", bus.dmem_rdata, 128'h0);
    checkOutput("rst_dmem_ack", bus.dmem_ack, 1'b0);
    bus.mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    settle();
    checkOutput("rst_rel_cyc", bus.mem_cyc, 1'b0);

    // Both held: grants alternate D, I, D, I with an idle cycle between.
    bus.dmem_we = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    checkOutput("rr_idle0", bus.mem_cyc, 1'b0);
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      tick();
      settle();
      checkOutput($sformatf("rr%0d_addr", k), bus.mem_addr, exp_d ? D_ADDR : I_ADDR);
      checkOutput($sformatf("rr%0d_cyc", k), bus.mem_cyc, 1'b1);
      tick();
      bus.mem_ack = 1'b1;
      settle();
      checkOutput($sformatf("rr%0d_dack", k), bus.dmem_ack, exp_d);
      checkOutput($sformatf("rr%0d_iack", k), bus.imem_ack, !exp_d);
      tick();
      bus.mem_ack = 1'b0;
      settle();
      checkOutput($sformatf("rr%0d_gap", k), bus.mem_cyc, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Single fetch, acked on its third serving cycle.
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("if_idle_cyc", bus.mem_cyc, 1'b0);
    tick();
    settle();
    checkOutput("if_addr", bus.mem_addr, I_ADDR);
    checkOutput("if_sel", bus.mem_sel, 16'hFFFF);
    checkOutput("if_we", bus.mem_we, 1'b0);
    checkOutput("if_wdata", bus.mem_wdata, 128'h0);
    tick();
    settle();
    checkOutput("if_wait_ack", bus.imem_ack, 1'b0);
    tick();
    bus.mem_ack = 1'b1;
    settle();
    checkOutput("if_ack", bus.imem_ack, 1'b1);
    checkOutput("if_rdata", bus.imem_rdata, RDATA);
    checkOutput("if_dack", bus.dmem_ack, 1'b0);
    checkOutput("if_err", bus.imem_err, 1'b0);
    tick();
    bus.mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("if_done_cyc", bus.mem_cyc, 1'b0);

    // Data write passes every field through untouched.
    bus.dmem_we = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    settle();
    checkOutput("dw_we", bus.mem_we, 1'b1);
    checkOutput("dw_sel", bus.mem_sel, 16'h0003);
    checkOutput("dw_addr", bus.mem_addr, D_ADDR);
    checkOutput("dw_wdata", bus.mem_wdata, 128'h1234);
    checkOutput("dw_pre_ack", bus.dmem_ack, 1'b0);
    bus.mem_ack = 1'b1;
    settle();
    checkOutput("dw_ack", bus.dmem_ack, 1'b1);
    checkOutput("dw_iack", bus.imem_ack, 1'b0);
    checkOutput("dw_rdata", bus.dmem_rdata, RDATA);
    tick();
    bus.mem_ack = 1'b0;
    bus.dmem_we = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Fetch withdraws before ack; a stray ack afterwards goes nowhere.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    settle();
    checkOutput("ab_cyc_on", bus.mem_cyc, 1'b1);
    bus.imem_cyc = 1'b0;
    settle();
    checkOutput("ab_cyc_off", bus.mem_cyc, 1'b0);
    checkOutput("ab_iack", bus.imem_ack, 1'b0);
    checkOutput("ab_ierr", bus.imem_err, 1'b0);
    tick();
    bus.imem_stb = 1'b0;
    bus.mem_ack  = 1'b1;
    settle();
    checkOutput("ab_stray_iack", bus.imem_ack, 1'b0);
    checkOutput("ab_stray_dack", bus.dmem_ack, 1'b0);
    checkOutput("ab_idle_cyc", bus.mem_cyc, 1'b0);
    tick();
    bus.mem_ack = 1'b0;

    // Data never acked: error on the fourth serving cycle only.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      settle();
      checkOutput($sformatf("to_err_c%0d", c), bus.dmem_err, (c == 4));
      checkOutput($sformatf("to_ack_c%0d", c), bus.dmem_ack, 1'b0);
      if (c < 4) tick();
    end
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    checkOutput("to_after_err", bus.dmem_err, 1'b0);
    checkOutput("to_after_cyc", bus.mem_cyc, 1'b0);
    tick();
    settle();
    checkOutput("to_tie_addr", bus.mem_addr, I_ADDR);
    bus.mem_ack = 1'b1;
    settle();
    checkOutput("to_tie_iack", bus.imem_ack, 1'b1);
    tick();
    bus.mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Ack landing on the would-be timeout cycle wins.
    tick();
    settle();
    checkOutput("ta_addr", bus.mem_addr, D_ADDR);
    tick();
    tick();
    tick();
    bus.mem_ack = 1'b1;
    settle();
    checkOutput("ta_ack", bus.dmem_ack, 1'b1);
    checkOutput("ta_err", bus.dmem_err, 1'b0);
    tick();
    bus.mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("ta_idle_cyc", bus.mem_cyc, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
